top_asyncfifo_wr: RTL and testbench

//   ASIC-to-FPGA result path; the write-direction counterpart of the SPI read path.

---
 rtl/top_asyncfifo_wr.sv | 178 +++++++++++++++++
 tb/tb_top_asyncfifo_wr.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/top_asyncfifo_wr.sv
// ASIC-to-FPGA result path: ASIC pushes words on clk_chip into an async FIFO that the
// FPGA drains on O_spi_sck; a config_paulse/config_req handshake frames each transfer.
module top_asyncfifo_wr #(
  parameter int SPI_WIDTH       = 32,
  parameter int ADDR_WIDTH_FIFO = 5,
  parameter int TX_WIDTH        = 20
) (
  input  logic                 clk_chip,
  input  logic                 reset_n_chip,
  input  logic                 O_spi_sck,
  input  logic                 O_spi_cs_n,
  output logic [SPI_WIDTH-1:0] O_spi_data,
  output logic                 O_spi_empty,
  output logic                 config_req,
  output logic                 config_ready,
  input  logic                 config_paulse,
  input  logic [3:0]           config_data,
  input  logic                 wr_req,
  input  logic [SPI_WIDTH-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 full
);
  localparam int A = ADDR_WIDTH_FIFO;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] CONFIG     = 3'd1;
  localparam logic [2:0] WR_DATA    = 3'd2;
  localparam logic [2:0] DRAIN      = 3'd3;
  localparam logic [2:0] RESET_FIFO = 3'd4;

  logic [2:0]          state_q, state_d;
  logic                config_req_q, config_req_d;
  logic [TX_WIDTH-1:0] wr_count_q, wr_count_d;
  logic [TX_WIDTH-1:0] wr_size_q, wr_size_d;
  logic [TX_WIDTH-1:0] size_dec;
  logic [2:0]          cs_sync_q, cs_sync_d;
  logic                cs_sync;
  logic                fifo_en_q, fifo_en_d;
  logic                reset_n_fifo;

  logic [A:0]          wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
  logic [A:0]          rq_meta_q, rq_meta_d, rq_sync_q, rq_sync_d;
  logic [A:0]          rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
  logic [A:0]          wq_meta_q, wq_meta_d, wq_sync_q, wq_sync_d;
  logic [SPI_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [SPI_WIDTH-1:0] mem [2**A];

  logic                wr_en, rd_en, fifo_drained;

  assign cs_sync      = cs_sync_q[2];
  assign config_ready = (state_q == IDLE);
  assign config_req   = config_req_q;
  assign wr_ready     = (state_q == WR_DATA) && !full && (wr_count_q != wr_size_q);
  assign wr_en        = wr_req && wr_ready;

  // FIFO is held in reset while idle; taken from a flop so the reset never glitches.
  assign reset_n_fifo = reset_n_chip && fifo_en_q;

  always_comb begin
    size_dec = '0;
    case (config_data)
      4'b0001, 4'b0010: size_dec = TX_WIDTH'(2048);
      4'b0011, 4'b0100: size_dec = TX_WIDTH'(256);
      4'b0101, 4'b0110: size_dec = TX_WIDTH'(512);
      4'b0111, 4'b1000: size_dec = TX_WIDTH'(43);
      default:          size_dec = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    config_req_d = config_req_q;
    wr_count_d   = wr_count_q;
    wr_size_d    = wr_size_q;
    cs_sync_d    = {cs_sync_q[1:0], O_spi_cs_n};
    case (state_q)
      IDLE: if (config_paulse) state_d = CONFIG;
      CONFIG: begin
        wr_size_d = size_dec;
        if (size_dec != '0) begin
          state_d      = WR_DATA;
          config_req_d = 1'b1;
        end else begin
          state_d = RESET_FIFO;
        end
      end
      WR_DATA: begin
        if (wr_en) wr_count_d = wr_count_q + TX_WIDTH'(1);
        if (wr_count_q == wr_size_q) state_d = DRAIN;
      end
      DRAIN: if (fifo_drained && cs_sync) state_d = RESET_FIFO;
      RESET_FIFO: begin
        wr_count_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // FPGA has seen the request once its chip select arrives.
    if ((state_q == WR_DATA || state_q == DRAIN) && !cs_sync) config_req_d = 1'b0;
    fifo_en_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      state_q      <= IDLE;
      config_req_q <= 1'b0;
      wr_count_q   <= '0;
      wr_size_q    <= '0;
      cs_sync_q    <= 3'b111;
      fifo_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      config_req_q <= config_req_d;
      wr_count_q   <= wr_count_d;
      wr_size_q    <= wr_size_d;
      cs_sync_q    <= cs_sync_d;
      fifo_en_q    <= fifo_en_d;
    end
  end

  // Write side (clk_chip)
  always_comb begin
    wr_bin_d  = wr_en ? wr_bin_q + (A+1)'(1) : wr_bin_q;
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    rq_meta_d = rd_gray_q;
    rq_sync_d = rq_meta_q;
  end

  assign full         = (wr_gray_q == {~rq_sync_q[A:A-1], rq_sync_q[A-2:0]});
  assign fifo_drained = (rq_sync_q == wr_gray_q);

  always_ff @(posedge clk_chip or negedge reset_n_fifo) begin
    if (!reset_n_fifo) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      rq_meta_q <= '0;
      rq_sync_q <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      rq_meta_q <= rq_meta_d;
      rq_sync_q <= rq_sync_d;
    end
  end

  always_ff @(posedge clk_chip) begin
    if (wr_en) mem[wr_bin_q[A-1:0]] <= wr_data;
  end

  // Read side (O_spi_sck)
  assign O_spi_empty = (rd_gray_q == wq_sync_q);
  assign rd_en       = !O_spi_cs_n && !O_spi_empty;
  assign O_spi_data  = rd_data_q;

  always_comb begin
    rd_bin_d  = rd_en ? rd_bin_q + (A+1)'(1) : rd_bin_q;
    rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
    rd_data_d = rd_en ? mem[rd_bin_q[A-1:0]] : rd_data_q;
    wq_meta_d = wr_gray_q;
    wq_sync_d = wq_meta_q;
  end

  always_ff @(posedge O_spi_sck or negedge reset_n_fifo) begin
    if (!reset_n_fifo) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      wq_meta_q <= '0;
      wq_sync_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      wq_meta_q <= wq_meta_d;
      wq_sync_q <= wq_sync_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_top_asyncfifo_wr.sv
// Bench for top_asyncfifo_wr: a word-queue model of FIFO contents checks every read word
// and the full/empty/wr_ready safety rules each cycle; directed transfers pin the handshake.
module tb_top_asyncfifo_wr;
  localparam int W = 32;

  logic         clk_chip = 1'b0, O_spi_sck = 1'b0;
  logic         reset_n_chip = 1'b1, O_spi_cs_n = 1'b1;
  logic         config_paulse = 1'b0, wr_req = 1'b0;
  logic [3:0]   config_data = '0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] O_spi_data;
  logic         O_spi_empty, config_req, config_ready, wr_ready, full;

  int checks = 0, failures = 0;
  int unsigned q[$];
  int wcnt = 0, cur_size = 0, rcv = 0;
  longint last_rx = 0;
  bit hold_valid = 0, rd_en = 0, cs_req = 0;

  top_asyncfifo_wr dut (
    .clk_chip(clk_chip), .reset_n_chip(reset_n_chip), .O_spi_sck(O_spi_sck),
    .O_spi_cs_n(O_spi_cs_n), .O_spi_data(O_spi_data), .O_spi_empty(O_spi_empty),
    .config_req(config_req), .config_ready(config_ready), .config_paulse(config_paulse),
    .config_data(config_data), .wr_req(wr_req), .wr_data(wr_data), .wr_ready(wr_ready),
    .full(full));

  always #5 clk_chip = ~clk_chip;
  always #7 O_spi_sck = ~O_spi_sck;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [3:0] cfg);
    case (cfg)
      4'd1, 4'd2: return 2048;
      4'd3, 4'd4: return 256;
      4'd5, 4'd6: return 512;
      4'd7, 4'd8: return 43;
      default:    return 0;
    endcase
  endfunction

  // Safety rules on the write side, every clk_chip cycle.
  initial forever begin
    @(negedge clk_chip); #3;
    if (reset_n_chip) begin
      if (wr_ready) begin
        chk("wr_ready_space", longint'(q.size() < 32), 1);
        chk("wr_ready_count", longint'(wcnt < cur_size), 1);
        chk("wr_ready_full", full, 0);
      end
      if (q.size() == 32) chk("full_at_depth", full, 1);
    end
  end

  // FPGA side: drive cs_n on sck negedge, decide whether the next edge reads.
  initial forever begin
    @(negedge O_spi_sck);
    O_spi_cs_n = !cs_req;
    #1;
    rd_en = !O_spi_cs_n && !O_spi_empty && reset_n_chip;
    if (q.size() == 0) chk("empty_when_no_data", O_spi_empty, 1);
  end

  initial forever begin
    int unsigned exp;
    @(posedge O_spi_sck); #1;
    if (rd_en) begin
      chk("read_nonempty", longint'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp = q.pop_front();
        chk("rd_data", O_spi_data, exp);
        last_rx = exp;
        rcv++;
        hold_valid = 1;
      end
    end else if (hold_valid) begin
      chk("rd_hold", O_spi_data, last_rx);
    end
  end

  task automatic do_write(input int n, input int base);
    int i = 0, guard = 0;
    logic ok;
    while (i < n && guard < 20000) begin
      @(negedge clk_chip); #1;
      wr_req = 1'b1;
      wr_data = W'(base + i);
      #1 ok = wr_ready;
      @(posedge clk_chip);
      if (ok) begin
        q.push_back(32'(base + i));
        i++;
        wcnt++;
      end
      guard++;
    end
    @(negedge clk_chip); #1 wr_req = 1'b0;
    chk("write_all_accepted", i, n);
  endtask

  task automatic start(input logic [3:0] cfg);
    @(negedge clk_chip);
    config_data = cfg;
    config_paulse = 1'b1;
    cur_size = size_of(cfg);
    wcnt = 0;
    @(negedge clk_chip);
    config_paulse = 1'b0;
  endtask

  // mode 0: plain, 1: stray pulse during writes, 2: cs_n held high until FIFO fills
  task automatic run_xfer(input logic [3:0] cfg, input int n, input int base, input int mode);
    int g;
    chk("ready_before_start", config_ready, 1);
    rcv = 0;
    hold_valid = 0;
    start(cfg);
    @(negedge clk_chip); #1;
    chk("req_after_config", config_req, 1);
    if (mode != 2) cs_req = 1;
    fork
      do_write(n, base);
      begin
        int g2 = 0;
        if (mode == 1) begin
          while (wcnt < 10 && g2 < 5000) begin @(negedge clk_chip); g2++; end
          config_data = 4'b0001;
          config_paulse = 1'b1;
          @(negedge clk_chip);
          config_paulse = 1'b0;
        end else if (mode == 2) begin
          while (wcnt < 32 && g2 < 5000) begin @(negedge clk_chip); g2++; end
          repeat (6) @(negedge clk_chip);
          #2;
          chk("bp_full", full, 1);
          chk("bp_wr_ready", wr_ready, 0);
          chk("bp_count", wcnt, 32);
          cs_req = 1;
        end
      end
    join
    g = 0;
    while (rcv < n && g < 20000) begin @(negedge clk_chip); g++; end
    #1;
    chk("rcv_count", rcv, n);
    chk("last_word", last_rx, base + n - 1);
    chk("req_dropped_on_cs", config_req, 0);
    chk("ready_after_writes", wr_ready, 0);
    hold_valid = 0;
    cs_req = 0;
    g = 0;
    while (!config_ready && g < 200) begin @(negedge clk_chip); g++; end
    chk("back_to_idle", config_ready, 1);
    @(negedge clk_chip); #1;
    chk("idle_data_cleared", O_spi_data, 0);
    chk("idle_empty", O_spi_empty, 1);
  endtask

  initial begin
    int g;
    #3 reset_n_chip = 1'b0;
    repeat (3) @(negedge clk_chip);
    #1;
    chk("rst_config_ready", config_ready, 1);
    chk("rst_config_req", config_req, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_empty", O_spi_empty, 1);
    chk("rst_data", O_spi_data, 0);
    chk("rst_full", full, 0);
    @(negedge clk_chip) reset_n_chip = 1'b1;
    repeat (2) @(negedge clk_chip);

    run_xfer(4'b0111, 43, 0, 0);
    run_xfer(4'b0011, 256, 32'h100, 2);

    // size 0: CONFIG -> RESET_FIFO -> IDLE, no request
    start(4'b0000);
    #1 chk("size0_req_cfg", config_req, 0);
    chk("size0_busy", config_ready, 0);
    @(negedge clk_chip); #1;
    chk("size0_req_rst", config_req, 0);
    chk("size0_wr_ready", wr_ready, 0);
    @(negedge clk_chip); #1;
    chk("size0_req_idle", config_req, 0);
    chk("size0_idle", config_ready, 1);
    chk("size0_empty", O_spi_empty, 1);

    run_xfer(4'b0111, 43, 32'h2000, 1);

    // reset after 100 of 512 words
    rcv = 0;
    hold_valid = 0;
    start(4'b0101);
    @(negedge clk_chip); #1 chk("mid_req", config_req, 1);
    cs_req = 1;
    do_write(100, 5000);
    g = 0;
    while (rcv < 100 && g < 5000) begin @(negedge clk_chip); g++; end
    chk("mid_rcv", rcv, 100);
    cs_req = 0;
    repeat (3) @(negedge O_spi_sck);
    hold_valid = 0;
    @(negedge clk_chip);
    reset_n_chip = 1'b0;
    q.delete();
    wcnt = 0;
    cur_size = 0;
    #1;
    chk("mid_rst_ready", config_ready, 1);
    chk("mid_rst_req", config_req, 0);
    chk("mid_rst_empty", O_spi_empty, 1);
    chk("mid_rst_data", O_spi_data, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    repeat (3) @(negedge clk_chip);
    reset_n_chip = 1'b1;
    repeat (2) @(negedge clk_chip);
    run_xfer(4'b0111, 43, 1000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", failures);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule
